// File: rtl/ctrl_fsm_mc.sv
// Multicycle Moore control unit. Each state lasts one cycle; FETCH, MEM_RD and MEM_WR stall on imem_ready/dmem_ready.
// Define CTRL_TRAP_EN to trap illegal instructions and time out memory waits after 2^TMO_W-1 cycles.
module ctrl_fsm_mc #(
    parameter int ALUF_W = 3,
    parameter int TMO_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic [1:0]        pc_src,
    output logic [ALUF_W-1:0] alu_funct,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              branch_op,
    output logic              load_a,
    output logic              load_b,
    output logic              load_alu_out,
    output logic              load_ir,
    output logic              load_mdr,
    output logic              reg_write,
    output logic [1:0]        mem_to_reg,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              dmem_write,
    output logic              reset_out,
    output logic [3:0]        state_o,
    output logic              trap
);

    localparam logic [3:0] RST_ST = 4'd0;
    localparam logic [3:0] FETCH  = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] EXEC_R = 4'd3;
    localparam logic [3:0] EXEC_I = 4'd4;
    localparam logic [3:0] MEM_RD = 4'd5;
    localparam logic [3:0] MEM_WR = 4'd6;
    localparam logic [3:0] WB_ALU = 4'd7;
    localparam logic [3:0] WB_MEM = 4'd8;
    localparam logic [3:0] LUI_WB = 4'd9;
    localparam logic [3:0] BRANCH = 4'd10;
    localparam logic [3:0] JAL    = 4'd11;
    localparam logic [3:0] TRAP   = 4'd15;

    localparam logic [6:0] OP_R    = 7'b1100110;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [ALUF_W-1:0] FN_PASS = ALUF_W'(3'b000);
    localparam logic [ALUF_W-1:0] FN_ADD  = ALUF_W'(3'b001);
    localparam logic [ALUF_W-1:0] FN_SUB  = ALUF_W'(3'b010);
    localparam logic [ALUF_W-1:0] FN_AND  = ALUF_W'(3'b011);
    localparam logic [ALUF_W-1:0] FN_SLT  = ALUF_W'(3'b111);

    logic [3:0]        state;
    logic [3:0]        nextState;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic              rLegal;
    logic              brLegal;
    logic [ALUF_W-1:0] rFn;
    logic              waitTmo;
    logic              unusedInstr;

    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign funct7      = instruction[31:25];
    assign brLegal     = (funct3[2:1] == 2'b00);
    assign unusedInstr = ^{instruction[24:15], instruction[11:7]};
    assign state_o     = state;

`ifdef CTRL_TRAP_EN
    localparam logic [3:0]       ILL_NEXT = TRAP;
    localparam logic [TMO_W-1:0] TMO_LIM  = {TMO_W{1'b1}};

    logic [TMO_W-1:0] waitCnt;

    // Only wait states ever hold, so any state change restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waitCnt <= '0;
        end else if (nextState != state) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + TMO_W'(1);
        end
    end

    assign waitTmo = (waitCnt == TMO_LIM - TMO_W'(1));
`else
    localparam logic [3:0] ILL_NEXT   = FETCH;
    localparam int         unusedTmoW = TMO_W;

    assign waitTmo = 1'b0;
`endif

    always_comb begin
        rLegal = 1'b1;
        rFn    = FN_PASS;
        case ({funct7, funct3})
            {7'b0000000, 3'b000}: rFn = FN_ADD;
            {7'b0100000, 3'b000}: rFn = FN_SUB;
            {7'b0000000, 3'b111}: rFn = FN_AND;
            {7'b0000000, 3'b010}: rFn = FN_SLT;
            default:              rLegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_ST;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            RST_ST: nextState = FETCH;
            FETCH: begin
                if (imem_ready)   nextState = DECODE;
                else if (waitTmo) nextState = TRAP;
            end
            DECODE: begin
                case (opcode)
                    OP_R:                   nextState = EXEC_R;
                    OP_S, OP_ADDI, OP_LD:   nextState = EXEC_I;
                    OP_LUI:                 nextState = LUI_WB;
                    OP_BR:                  nextState = BRANCH;
                    OP_JAL:                 nextState = JAL;
                    default:                nextState = ILL_NEXT;
                endcase
            end
            EXEC_R: nextState = rLegal ? WB_ALU : ILL_NEXT;
            EXEC_I: begin
                if (opcode == OP_S)       nextState = MEM_WR;
                else if (opcode == OP_LD) nextState = MEM_RD;
                else                      nextState = WB_ALU;
            end
            MEM_RD: begin
                if (dmem_ready)   nextState = WB_MEM;
                else if (waitTmo) nextState = TRAP;
            end
            MEM_WR: begin
                if (dmem_ready)   nextState = FETCH;
                else if (waitTmo) nextState = TRAP;
            end
            BRANCH:  nextState = brLegal ? FETCH : ILL_NEXT;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        pc_src        = 2'b00;
        alu_funct     = FN_PASS;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_op     = 1'b0;
        load_a        = 1'b0;
        load_b        = 1'b0;
        load_alu_out  = 1'b0;
        load_ir       = 1'b0;
        load_mdr      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 2'b00;
        imem_req      = 1'b0;
        dmem_req      = 1'b0;
        dmem_write    = 1'b0;
        reset_out     = 1'b0;
        trap          = 1'b0;
        case (state)
            RST_ST: reset_out = 1'b1;
            FETCH: begin
                imem_req  = 1'b1;
                alu_src_b = 2'b01;
                alu_funct = FN_ADD;
                load_ir   = imem_ready;
                pc_write  = imem_ready;
            end
            DECODE: begin
                load_a       = 1'b1;
                load_b       = 1'b1;
                load_alu_out = 1'b1;
                alu_src_b    = 2'b11;
                alu_funct    = FN_ADD;
            end
            EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_funct    = rFn;
                load_alu_out = rLegal;
            end
            EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_funct    = FN_ADD;
                load_alu_out = 1'b1;
            end
            MEM_RD: begin
                dmem_req = 1'b1;
                load_mdr = dmem_ready;
            end
            MEM_WR: begin
                dmem_req   = 1'b1;
                dmem_write = 1'b1;
            end
            WB_ALU: reg_write = 1'b1;
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
            end
            LUI_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_funct     = FN_SUB;
                pc_src        = 2'b01;
                branch_op     = instruction[12];
                pc_write_cond = brLegal;
            end
            JAL: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b11;
                pc_write   = 1'b1;
                pc_src     = 2'b01;
            end
`ifdef CTRL_TRAP_EN
            TRAP: begin
                trap     = 1'b1;
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_fsm_mc.sv
// Bench for ctrl_fsm_mc: vector table, reset/timeout sequences, random instructions against a per-instruction summary model.
module tb_ctrl_fsm_mc;
    localparam int ALUF_W = 3;
    localparam int TMO_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       instruction;
    logic              imem_ready, dmem_ready;
    logic [1:0]        pc_src;
    logic [ALUF_W-1:0] alu_funct;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic              pc_write, pc_write_cond, branch_op;
    logic              load_a, load_b, load_alu_out, load_ir, load_mdr;
    logic              reg_write;
    logic [1:0]        mem_to_reg;
    logic              imem_req, dmem_req, dmem_write, reset_out;
    logic [3:0]        state_o;
    logic              trap;

    ctrl_fsm_mc #(.ALUF_W(ALUF_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .pc_src(pc_src), .alu_funct(alu_funct), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_op(branch_op),
        .load_a(load_a), .load_b(load_b), .load_alu_out(load_alu_out), .load_ir(load_ir),
        .load_mdr(load_mdr), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_write(dmem_write),
        .reset_out(reset_out), .state_o(state_o), .trap(trap)
    );

    always #5 clk = ~clk;

    // Per-instruction summary: cycle count and how often each strobe fired.
    typedef struct {
        logic [31:0] instr;
        int iw, dw;
        int cyc, rw, m2r, mdr, dwr, pcw, pcc, bop, fn, trp;
    } vec_t;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input int act, input int exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic vec_t mkv(input logic [31:0] ins, input int iw, input int dw, input int cyc,
                                 input int rw, input int m2r, input int mdr, input int dwr,
                                 input int pcw, input int pcc, input int bop, input int fn, input int trp);
        vec_t v;
        v.instr = ins; v.iw = iw; v.dw = dw; v.cyc = cyc; v.rw = rw; v.m2r = m2r; v.mdr = mdr;
        v.dwr = dwr; v.pcw = pcw; v.pcc = pcc; v.bop = bop; v.fn = fn; v.trp = trp;
        return v;
    endfunction

    // Reference: instruction class -> cycle budget and strobe counts.
    function automatic vec_t model(input logic [31:0] ins, input int iw, input int dw);
        vec_t v;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ill;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; ill = 0;
        v = mkv(ins, iw, dw, 2 + iw, 0, -1, 0, 0, 1, 0, -1, -1, 0);
        case (op)
            7'b1100110: begin
                v.cyc += 1;
                if      (f7 == 7'd0  && f3 == 3'd0) v.fn = 1;
                else if (f7 == 7'd32 && f3 == 3'd0) v.fn = 2;
                else if (f7 == 7'd0  && f3 == 3'd7) v.fn = 3;
                else if (f7 == 7'd0  && f3 == 3'd2) v.fn = 7;
                else ill = 1;
                if (!ill) begin v.cyc += 1; v.rw = 1; v.m2r = 0; end
            end
            7'b0010011: begin v.cyc += 2; v.rw = 1; v.m2r = 0; v.fn = 1; end
            7'b0000011: begin v.cyc += 3 + dw; v.rw = 1; v.m2r = 1; v.mdr = 1; v.fn = 1; end
            7'b0100011: begin v.cyc += 2 + dw; v.dwr = dw + 1; v.fn = 1; end
            7'b0110111: begin v.cyc += 1; v.rw = 1; v.m2r = 2; end
            7'b1100111: begin
                v.cyc += 1;
                if (f3 < 3'd2) begin v.pcc = 1; v.bop = int'(f3); v.fn = 2; end
                else ill = 1;
            end
            7'b1101111: begin v.cyc += 1; v.rw = 1; v.m2r = 3; v.pcw = 2; end
            default: ill = 1;
        endcase
`ifdef CTRL_TRAP_EN
        if (ill) begin v.cyc += 1; v.pcw += 1; v.trp = 1; end
`endif
        return v;
    endfunction

    // Starts just after a negedge in FETCH; returns at the negedge of the next FETCH.
    task automatic runInstr(input logic [31:0] ins, input int iw, input int dw, output vec_t a);
        int fetchSeen, dmemSeen, guard;
        bit seenIr;
        fetchSeen = 0; dmemSeen = 0; guard = 0; seenIr = 0;
        a = mkv(ins, iw, dw, 0, 0, -1, 0, 0, 0, 0, -1, -1, 0);
        instruction = ins;
        forever begin
            if (seenIr && imem_req) break;
            if (guard++ > 100) begin
                nCmp++; nBad++;
                $display("FAIL cycle budget: instruction %h did not return to fetch", ins);
                break;
            end
            imem_ready = imem_req && (fetchSeen >= iw);
            dmem_ready = dmem_req && (dmemSeen >= dw);
            #1;
            a.cyc++;
            if (imem_req) fetchSeen++;
            if (dmem_req) dmemSeen++;
            if (load_ir) seenIr = 1;
            a.rw  += int'(reg_write);
            a.mdr += int'(load_mdr);
            a.dwr += int'(dmem_write);
            a.pcw += int'(pc_write);
            a.pcc += int'(pc_write_cond);
            a.trp += int'(trap);
            if (reg_write) a.m2r = int'(mem_to_reg);
            if (pc_write_cond) a.bop = int'(branch_op);
            if (alu_src_a) a.fn = int'(alu_funct);
            if (pc_write && pc_write_cond) chk("pc_write with pc_write_cond", 1, 0);
            @(negedge clk);
        end
        imem_ready = 0;
        dmem_ready = 0;
    endtask

    task automatic cmpVec(input string tag, input vec_t a, input vec_t e);
        chk({tag, " cycles"}, a.cyc, e.cyc);
        chk({tag, " reg_write"}, a.rw, e.rw);
        chk({tag, " mem_to_reg"}, a.m2r, e.m2r);
        chk({tag, " load_mdr"}, a.mdr, e.mdr);
        chk({tag, " dmem_write"}, a.dwr, e.dwr);
        chk({tag, " pc_write"}, a.pcw, e.pcw);
        chk({tag, " pc_write_cond"}, a.pcc, e.pcc);
        chk({tag, " branch_op"}, a.bop, e.bop);
        chk({tag, " trap"}, a.trp, e.trp);
        if (e.fn >= 0) chk({tag, " alu_funct"}, a.fn, e.fn);
    endtask

    vec_t vecs[$];
    vec_t act;

    initial begin
        int illCyc, illPcw, illTrp, rIllCyc;
        int waits, trapSeen, trapState, trapSrc;
`ifdef CTRL_TRAP_EN
        illCyc = 3; illPcw = 2; illTrp = 1; rIllCyc = 4;
`else
        illCyc = 2; illPcw = 1; illTrp = 0; rIllCyc = 3;
`endif
        //                ins                                   iw dw cyc rw m2r mdr dwr pcw pcc bop fn trp
        vecs.push_back(mkv(mk(7'd0,  3'd0, 7'b1100110),        0, 0, 4, 1, 0, 0, 0, 1, 0, -1, 1, 0));
        vecs.push_back(mkv(mk(7'd32, 3'd0, 7'b1100110),        2, 0, 6, 1, 0, 0, 0, 1, 0, -1, 2, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd7, 7'b1100110),        0, 0, 4, 1, 0, 0, 0, 1, 0, -1, 3, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd2, 7'b1100110),        0, 0, 4, 1, 0, 0, 0, 1, 0, -1, 7, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd3, 7'b0000011),        0, 3, 8, 1, 1, 1, 0, 1, 0, -1, 1, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd3, 7'b0100011),        0, 2, 6, 0, -1, 0, 3, 1, 0, -1, 1, 0));
        vecs.push_back(mkv(mk(7'd5,  3'd0, 7'b0010011),        1, 0, 5, 1, 0, 0, 0, 1, 0, -1, 1, 0));
        vecs.push_back(mkv(mk(7'd9,  3'd4, 7'b0110111),        0, 0, 3, 1, 2, 0, 0, 1, 0, -1, -1, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd1, 7'b1100111),        0, 0, 3, 0, -1, 0, 0, 1, 1, 1, 2, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd0, 7'b1100111),        1, 0, 4, 0, -1, 0, 0, 1, 1, 0, 2, 0));
        vecs.push_back(mkv(mk(7'd3,  3'd6, 7'b1101111),        0, 0, 3, 1, 3, 0, 0, 2, 0, -1, -1, 0));
        vecs.push_back(mkv(mk(7'd0,  3'd0, 7'b0000000),        0, 0, illCyc, 0, -1, 0, 0, illPcw, 0, -1, -1, illTrp));
        vecs.push_back(mkv(mk(7'd1,  3'd0, 7'b1100110),        0, 0, rIllCyc, 0, -1, 0, 0, illPcw, 0, -1, -1, illTrp));

        rst = 1; instruction = 0; imem_ready = 0; dmem_ready = 0;
        #12;
        chk("reset state_o", int'(state_o), 0);
        chk("reset reset_out", int'(reset_out), 1);
        chk("reset imem_req", int'(imem_req), 0);
        chk("reset pc_write", int'(pc_write), 0);
        chk("reset reg_write", int'(reg_write), 0);
        chk("reset trap", int'(trap), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("post-reset imem_req", int'(imem_req), 1);
        chk("post-reset reset_out", int'(reset_out), 0);

        foreach (vecs[i]) begin
            runInstr(vecs[i].instr, vecs[i].iw, vecs[i].dw, act);
            cmpVec($sformatf("vec%0d", i), act, vecs[i]);
        end

        // Reset while a store is waiting on the data memory.
        instruction = mk(7'd0, 3'd3, 7'b0100011);
        imem_ready = 1;
        @(negedge clk);
        imem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("memwr dmem_write", int'(dmem_write), 1);
        rst = 1;
        #1;
        chk("rst dmem_write", int'(dmem_write), 0);
        chk("rst state_o", int'(state_o), 0);
        chk("rst reset_out", int'(reset_out), 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("release imem_req", int'(imem_req), 1);
        chk("release reset_out", int'(reset_out), 0);

        // Instruction memory that never answers.
        waits = 0; trapSeen = 0; trapState = -1; trapSrc = -1;
        for (int i = 0; i < 40 && trapSeen == 0; i++) begin
            #1;
            if (trap) begin trapSeen++; trapState = int'(state_o); trapSrc = int'(pc_src); end
            else if (imem_req) waits++;
            @(negedge clk);
        end
`ifdef CTRL_TRAP_EN
        chk("timeout wait cycles", waits, 15);
        chk("timeout trap", trapSeen, 1);
        chk("timeout state_o", trapState, 15);
        chk("timeout pc_src", trapSrc, 2);
`else
        chk("no-timeout wait cycles", waits, 40);
        chk("no-timeout trap", trapSeen, 0);
`endif
        chk("after wait imem_req", int'(imem_req), 1);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ins;
            int iw, dw;
            vec_t exp;
            ins = $urandom;
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            case ($urandom_range(0, 8))
                0: begin
                    ins[6:0] = 7'b1100110;
                    case ($urandom_range(0, 3))
                        0: {ins[31:25], ins[14:12]} = {7'd0, 3'd0};
                        1: {ins[31:25], ins[14:12]} = {7'd32, 3'd0};
                        2: {ins[31:25], ins[14:12]} = {7'd0, 3'd7};
                        default: {ins[31:25], ins[14:12]} = {7'd0, 3'd2};
                    endcase
                end
                1: ins[6:0] = 7'b1100110;
                2: ins[6:0] = 7'b0010011;
                3: ins[6:0] = 7'b0000011;
                4: ins[6:0] = 7'b0100011;
                5: ins[6:0] = 7'b0110111;
                6: begin ins[6:0] = 7'b1100111; ins[14:12] = 3'($urandom_range(0, 3)); end
                7: ins[6:0] = 7'b1101111;
                default: ;
            endcase
            exp = model(ins, iw, dw);
            runInstr(ins, iw, dw, act);
            cmpVec($sformatf("rnd%0d", n), act, exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
